issue_queue: RTL and testbench

Out-of-order issue queue between the renaming register file (decode/rename stage) and the execute stage. It accepts renamed instructions carrying physical source and destination tags, and tracks operand readiness through write-back tag broadcasts. Each cycle it issues the oldest instruction whose operands are both ready. Storage is an age-ordered collapsing queue: slot 0 always holds the oldest entry.

---
 rtl/issue_queue.sv | 138 +++++++++++++
 tb/tb_issue_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : issue_queue
//  Purpose  : Age-ordered collapsing issue queue with tag wakeup and
//             oldest-ready select between rename and execute.
//  Revision : 1.0  initial release
// ============================================================================
module issue_queue #(
    parameter int DEPTH_WIDTH   = 3,
    parameter int PREG_WIDTH    = 6,
    parameter int AL_WIDTH      = 5,
    parameter int PAYLOAD_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [PREG_WIDTH-1:0]    enq_rs_tag,
    input  logic [PREG_WIDTH-1:0]    enq_rt_tag,
    input  logic                     enq_rs_ready,
    input  logic                     enq_rt_ready,
    input  logic [PREG_WIDTH-1:0]    enq_rd_tag,
    input  logic [AL_WIDTH-1:0]      enq_al_index,
    input  logic [PAYLOAD_WIDTH-1:0] enq_payload,
    input  logic                     wb_valid,
    input  logic [PREG_WIDTH-1:0]    wb_tag,
    output logic                     iss_valid,
    input  logic                     iss_ready,
    output logic [PREG_WIDTH-1:0]    iss_rs_tag,
    output logic [PREG_WIDTH-1:0]    iss_rt_tag,
    output logic [PREG_WIDTH-1:0]    iss_rd_tag,
    output logic [AL_WIDTH-1:0]      iss_al_index,
    output logic [PAYLOAD_WIDTH-1:0] iss_payload,
    output logic [DEPTH_WIDTH:0]     count
);

    localparam int                   DEPTH   = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] C_DEPTH = (DEPTH_WIDTH+1)'(DEPTH);
    localparam logic [DEPTH_WIDTH:0] C_ONE   = (DEPTH_WIDTH+1)'(1);
    localparam logic [DEPTH_WIDTH:0] C_ZERO  = '0;

    typedef struct packed {
        logic                     valid;
        logic [PREG_WIDTH-1:0]    rs_tag;
        logic                     rs_rdy;
        logic [PREG_WIDTH-1:0]    rt_tag;
        logic                     rt_rdy;
        logic [PREG_WIDTH-1:0]    rd_tag;
        logic [AL_WIDTH-1:0]      al_index;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } entry_t;

    entry_t                 r_q    [DEPTH];
    entry_t                 w_woke [DEPTH];
    entry_t                 w_nxt  [DEPTH];
    entry_t                 w_new;
    logic [DEPTH_WIDTH:0]   r_count;
    logic [DEPTH_WIDTH:0]   w_count_nxt;
    logic [DEPTH_WIDTH:0]   w_ins_pos;
    logic [DEPTH_WIDTH-1:0] w_sel;
    logic                   w_found;
    logic                   w_issue;
    logic                   w_enq;
    logic                   w_wb_live;

    assign count     = r_count;
    assign enq_ready = (r_count != C_DEPTH);
    assign w_enq     = enq_valid && enq_ready;
    assign w_issue   = w_found && iss_ready;
    assign w_wb_live = wb_valid && (wb_tag != '0);

    // Oldest-ready select: scan from the youngest so the lowest index wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_q[i].valid && r_q[i].rs_rdy && r_q[i].rt_rdy) begin
                w_found = 1'b1;
                w_sel   = DEPTH_WIDTH'(i);
            end
        end
    end

    assign iss_valid    = w_found;
    assign iss_rs_tag   = w_found ? r_q[w_sel].rs_tag   : '0;
    assign iss_rt_tag   = w_found ? r_q[w_sel].rt_tag   : '0;
    assign iss_rd_tag   = w_found ? r_q[w_sel].rd_tag   : '0;
    assign iss_al_index = w_found ? r_q[w_sel].al_index : '0;
    assign iss_payload  = w_found ? r_q[w_sel].payload  : '0;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_woke[i] = r_q[i];
            if (w_wb_live && (r_q[i].rs_tag == wb_tag)) w_woke[i].rs_rdy = 1'b1;
            if (w_wb_live && (r_q[i].rt_tag == wb_tag)) w_woke[i].rt_rdy = 1'b1;
        end
    end

    // Incoming entry sees the same-cycle broadcast so it never misses a wakeup.
    always_comb begin
        w_new.valid    = 1'b1;
        w_new.rs_tag   = enq_rs_tag;
        w_new.rs_rdy   = enq_rs_ready || (enq_rs_tag == '0) || (wb_valid && (wb_tag == enq_rs_tag));
        w_new.rt_tag   = enq_rt_tag;
        w_new.rt_rdy   = enq_rt_ready || (enq_rt_tag == '0) || (wb_valid && (wb_tag == enq_rt_tag));
        w_new.rd_tag   = enq_rd_tag;
        w_new.al_index = enq_al_index;
        w_new.payload  = enq_payload;
    end

    always_comb begin
        w_ins_pos = w_issue ? (r_count - C_ONE) : r_count;
        for (int i = 0; i < DEPTH - 1; i++) begin
            w_nxt[i] = (w_issue && (DEPTH_WIDTH'(i) >= w_sel)) ? w_woke[i+1] : w_woke[i];
        end
        w_nxt[DEPTH-1] = w_issue ? '0 : w_woke[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            if (w_enq && (w_ins_pos == (DEPTH_WIDTH+1)'(i))) w_nxt[i] = w_new;
        end
        w_count_nxt = r_count + (w_enq ? C_ONE : C_ZERO) - (w_issue ? C_ONE : C_ZERO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
        end else if (flush) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_q[i].valid <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            for (int i = 0; i < DEPTH; i++) r_q[i] <= w_nxt[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_queue
//  Purpose  : Directed scenarios plus random traffic for issue_queue against
//             a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_issue_queue;

    localparam int DW = 3, PW = 6, AW = 5, LW = 32, DEPTH = 8;

    logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic          enq_valid = 1'b0, enq_ready;
    logic [PW-1:0] enq_rs_tag = '0, enq_rt_tag = '0, enq_rd_tag = '0;
    logic          enq_rs_ready = 1'b0, enq_rt_ready = 1'b0;
    logic [AW-1:0] enq_al_index = '0;
    logic [LW-1:0] enq_payload = '0;
    logic          wb_valid = 1'b0;
    logic [PW-1:0] wb_tag = '0;
    logic          iss_valid, iss_ready = 1'b0;
    logic [PW-1:0] iss_rs_tag, iss_rt_tag, iss_rd_tag;
    logic [AW-1:0] iss_al_index;
    logic [LW-1:0] iss_payload;
    logic [DW:0]   count;

    always #5 clk = ~clk;

    issue_queue #(.DEPTH_WIDTH(DW), .PREG_WIDTH(PW), .AL_WIDTH(AW), .PAYLOAD_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_rs_tag(enq_rs_tag), .enq_rt_tag(enq_rt_tag),
        .enq_rs_ready(enq_rs_ready), .enq_rt_ready(enq_rt_ready),
        .enq_rd_tag(enq_rd_tag), .enq_al_index(enq_al_index), .enq_payload(enq_payload),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs_tag(iss_rs_tag), .iss_rt_tag(iss_rt_tag), .iss_rd_tag(iss_rd_tag),
        .iss_al_index(iss_al_index), .iss_payload(iss_payload), .count(count)
    );

    typedef struct {
        logic [PW-1:0] rs, rt, rd;
        logic          rsr, rtr;
        logic [AW-1:0] al;
        logic [LW-1:0] pl;
    } ent_t;

    ent_t mq[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_sel();
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].rsr && mq[i].rtr) return i;
        return -1;
    endfunction

    task automatic check_outputs(input string ctx);
        int   k;
        ent_t e;
        k = model_sel();
        e = '{rs: '0, rt: '0, rd: '0, rsr: 1'b0, rtr: 1'b0, al: '0, pl: '0};
        if (k >= 0) e = mq[k];
        check({ctx, ".count"},     64'(count),        64'(mq.size()));
        check({ctx, ".enq_ready"}, 64'(enq_ready),    64'(mq.size() < DEPTH));
        check({ctx, ".iss_valid"}, 64'(iss_valid),    64'(k >= 0));
        check({ctx, ".iss_rs"},    64'(iss_rs_tag),   64'(e.rs));
        check({ctx, ".iss_rt"},    64'(iss_rt_tag),   64'(e.rt));
        check({ctx, ".iss_rd"},    64'(iss_rd_tag),   64'(e.rd));
        check({ctx, ".iss_al"},    64'(iss_al_index), 64'(e.al));
        check({ctx, ".iss_pl"},    64'(iss_payload),  64'(e.pl));
    endtask

    // Apply the currently driven inputs to the model, advance one edge, check.
    task automatic tick(input string ctx);
        int   k;
        bit   do_iss, do_enq;
        ent_t e;
        k      = model_sel();
        do_iss = (k >= 0) && iss_ready;
        do_enq = enq_valid && (mq.size() < DEPTH);
        if (flush) begin
            mq.delete();
        end else begin
            if (wb_valid && wb_tag != 0) begin
                foreach (mq[i]) begin
                    if (mq[i].rs == wb_tag) mq[i].rsr = 1'b1;
                    if (mq[i].rt == wb_tag) mq[i].rtr = 1'b1;
                end
            end
            if (do_iss) mq.delete(k);
            if (do_enq) begin
                e.rs  = enq_rs_tag;
                e.rt  = enq_rt_tag;
                e.rd  = enq_rd_tag;
                e.al  = enq_al_index;
                e.pl  = enq_payload;
                e.rsr = enq_rs_ready || (enq_rs_tag == 0) || (wb_valid && wb_tag == enq_rs_tag);
                e.rtr = enq_rt_ready || (enq_rt_tag == 0) || (wb_valid && wb_tag == enq_rt_tag);
                mq.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs(ctx);
    endtask

    task automatic idle();
        flush = 1'b0; enq_valid = 1'b0; wb_valid = 1'b0; wb_tag = '0; iss_ready = 1'b0;
        enq_rs_ready = 1'b0; enq_rt_ready = 1'b0;
    endtask

    task automatic set_enq(input logic [PW-1:0] rs, input logic rsr, input logic [PW-1:0] rt,
                           input logic rtr, input logic [PW-1:0] rd, input logic [AW-1:0] al);
        enq_valid = 1'b1; enq_rs_tag = rs; enq_rs_ready = rsr; enq_rt_tag = rt; enq_rt_ready = rtr;
        enq_rd_tag = rd; enq_al_index = al; enq_payload = $urandom;
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single ready instruction
        set_enq(6'd33, 1'b1, 6'd0, 1'b0, 6'd40, 5'd2);
        tick("t1_enq");
        check("t1_rd", 64'(iss_rd_tag), 64'd40);
        check("t1_al", 64'(iss_al_index), 64'd2);
        idle(); iss_ready = 1'b1;
        tick("t1_iss");
        check("t1_cnt0", 64'(count), 64'd0);

        // 2: younger ready instruction passes older blocked one
        idle(); set_enq(6'd41, 1'b0, 6'd0, 1'b0, 6'd11, 5'd3);
        tick("t2_b");
        set_enq(6'd12, 1'b1, 6'd13, 1'b1, 6'd14, 5'd4); iss_ready = 1'b1;
        tick("t2_c");
        check("t2_c_first", 64'(iss_rd_tag), 64'd14);
        idle(); iss_ready = 1'b1;
        tick("t2_issc");
        iss_ready = 1'b1; wb_valid = 1'b1; wb_tag = 6'd41;
        tick("t2_wb");
        check("t2_b_next", 64'(iss_rd_tag), 64'd11);
        idle(); iss_ready = 1'b1;
        tick("t2_issb");

        // 3: fill, overflow attempt, then drain in order
        for (int i = 0; i < 9; i++) begin
            idle(); set_enq(6'd50, 1'b0, 6'd0, 1'b0, 6'(20 + i), 5'(i));
            tick("t3_fill");
        end
        check("t3_full", 64'(enq_ready), 64'd0);
        idle(); wb_valid = 1'b1; wb_tag = 6'd50;
        tick("t3_wb");
        for (int i = 0; i < 8; i++) begin
            check("t3_order", 64'(iss_rd_tag), 64'(20 + i));
            idle(); iss_ready = 1'b1;
            tick("t3_drain");
        end

        // 4: same-cycle wakeup bypass on insert
        idle(); set_enq(6'd7, 1'b1, 6'd45, 1'b0, 6'd46, 5'd5); wb_valid = 1'b1; wb_tag = 6'd45;
        tick("t4");
        check("t4_valid", 64'(iss_valid), 64'd1);
        idle(); iss_ready = 1'b1;
        tick("t4_drain");

        // 5: enq + issue of slot 1 + wakeup on one edge
        idle(); set_enq(6'd20, 1'b0, 6'd0, 1'b0, 6'd30, 5'd0); tick("t5_a");
        idle(); set_enq(6'd0,  1'b0, 6'd0, 1'b0, 6'd31, 5'd1); tick("t5_b");
        idle(); set_enq(6'd21, 1'b0, 6'd0, 1'b0, 6'd32, 5'd2); tick("t5_c");
        idle(); set_enq(6'd20, 1'b0, 6'd0, 1'b0, 6'd33, 5'd3);
        iss_ready = 1'b1; wb_valid = 1'b1; wb_tag = 6'd20;
        tick("t5_all");
        check("t5_cnt", 64'(count), 64'd3);
        idle(); iss_ready = 1'b1; tick("t5_d0");
        check("t5_new_next", 64'(iss_rd_tag), 64'd33);
        wb_valid = 1'b1; wb_tag = 6'd21; iss_ready = 1'b1; tick("t5_d1");
        idle(); iss_ready = 1'b1; tick("t5_d2");

        // 6: flush beats enq/wakeup; then asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) begin
            idle(); set_enq(6'd60, 1'b0, 6'd0, 1'b0, 6'(i), 5'(i)); tick("t6_fill");
        end
        idle(); flush = 1'b1; set_enq(6'd1, 1'b1, 6'd2, 1'b1, 6'd3, 5'd3); wb_valid = 1'b1; wb_tag = 6'd60;
        tick("t6_flush");
        check("t6_cnt0", 64'(count), 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle(); set_enq(6'd1, 1'b1, 6'd2, 1'b1, 6'(9 + i), 5'(i)); tick("t6_refill");
        end
        idle();
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        check("t6_rst_cnt", 64'(count), 64'd0);
        check("t6_rst_ivalid", 64'(iss_valid), 64'd0);
        check("t6_rst_erdy", 64'(enq_ready), 64'd1);
        check("t6_rst_ird", 64'(iss_rd_tag), 64'd0);
        @(negedge clk);
        check_outputs("t6_in_rst");
        rst_n = 1'b1;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            flush     = ($urandom_range(0, 99) == 0);
            iss_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = ($urandom_range(0, 1) == 1);
            wb_tag    = 6'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0)
                set_enq(6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                        6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                        6'($urandom), 5'($urandom));
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
